pulse_bcd_counter: RTL and testbench

//   Counts rising edges of an asynchronous pulse input in a DIGITS-wide decimal (BCD) counter.

---
 rtl/pulse_gen_pkg.sv | 25 ++
 rtl/bcd_digit_cell.sv | 34 +++
 rtl/pulse_bcd_counter.sv | 149 ++++++++++++++
 tb/tb_pulse_bcd_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared BCD digit type and single-digit increment helper
// Contents: BCD_W, BCD_MAX, bcd_digit_t, bcd_inc(d, cin) -> {cout, d_next}
package pulse_gen_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Returns {carry_out, next_digit}. A digit at 9 (or anything above, which
    // can only appear through corruption) rolls to 0 and carries.
    function automatic logic [BCD_W:0] bcd_inc(input bcd_digit_t d, input logic cin);
        logic [BCD_W:0] r;
        r = {1'b0, d};
        if (cin) begin
            if (d >= BCD_MAX) begin
                r = {1'b1, {BCD_W{1'b0}}};
            end else begin
                r = {1'b0, d + 4'd1};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit register with clear, carry-in and carry-out
// Ports: clock, reset_n (async, active-low), clr (sync clear), cin (carry-in),
//        q (current digit), q_next (digit after cin, ignoring clr), cout (carry-out)
module bcd_digit_cell
    import pulse_gen_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       cin,
    output bcd_digit_t q,
    output bcd_digit_t q_next,
    output logic       cout
);

    logic [BCD_W:0] sum;

    assign sum    = bcd_inc(q, cin);
    // q_next deliberately excludes clr: the gated snapshot needs the value
    // including this cycle's increment even while the window is restarting.
    assign q_next = sum[BCD_W-1:0];
    assign cout   = sum[BCD_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/pulse_bcd_counter.sv
// rtl/pulse_bcd_counter.sv - decimal counter of asynchronous pulse rising edges
// Ports: clock, reset_n (async, active-low), pulse_in (async source), clear (sync),
//        hold (freeze display), bcd_out[4*DIGITS] (digit 0 = units), overflow (sticky wrap),
//        count_valid (one-cycle strobe on display update)
// Macro PULSE_CNT_GATE_EN: gated frequency-meter mode (pulses per GATE_CYCLES window).
module pulse_bcd_counter
    import pulse_gen_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      pulse_in,
    input  logic                      clear,
    input  logic                      hold,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      overflow,
    output logic                      count_valid
);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      sync_d;
    logic                      inc;
    logic [DIGITS:0]           carry;
    logic [BCD_W*DIGITS-1:0]   acc;
    logic [BCD_W*DIGITS-1:0]   acc_next;
    logic                      acc_clr;
    logic                      wrap;
    logic                      ovf_flag;

    // Synchronizer and rising-edge detect. History resets to 0, so a pulse
    // held high across reset release is counted once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign inc      = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign carry[0] = inc;
    assign wrap     = carry[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (acc_clr),
            .cin     (carry[g]),
            .q       (acc[BCD_W*g +: BCD_W]),
            .q_next  (acc_next[BCD_W*g +: BCD_W]),
            .cout    (carry[g+1])
        );
    end

`ifdef PULSE_CNT_GATE_EN
    localparam int             TW     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(GATE_CYCLES - 1);

    logic [TW-1:0] gate_timer;
    logic          terminal;

    assign terminal = (gate_timer == T_LAST);
    assign acc_clr  = clear | terminal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_flag <= 1'b0;
        end else if (clear || terminal) begin
            ovf_flag <= 1'b0;
        end else if (wrap) begin
            ovf_flag <= 1'b1;
        end
    end

    // Display snapshots the closing window, including an increment landing
    // on the terminal cycle. The window restarts even while hold is set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gate_timer  <= '0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (clear) begin
                gate_timer <= '0;
                bcd_out    <= '0;
                overflow   <= 1'b0;
            end else begin
                gate_timer <= terminal ? '0 : gate_timer + TW'(1);
                if (terminal && !hold) begin
                    bcd_out     <= acc_next;
                    overflow    <= ovf_flag | wrap;
                    count_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic upd_q;
    logic held_q;

    assign acc_clr = clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_flag <= 1'b0;
        end else if (clear) begin
            ovf_flag <= 1'b0;
        end else if (wrap) begin
            ovf_flag <= 1'b1;
        end
    end

    // Display follows the accumulator one cycle after each change. held_q
    // remembers that hold was active so its release forces a reload strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcd_out     <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
            upd_q       <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            held_q      <= hold;
            if (clear) begin
                bcd_out  <= '0;
                overflow <= 1'b0;
                upd_q    <= 1'b0;
            end else begin
                upd_q <= (acc_next != acc);
                if (!hold && (upd_q || held_q)) begin
                    bcd_out     <= acc;
                    overflow    <= ovf_flag;
                    count_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// tb/tb_pulse_bcd_counter.sv - self-checking bench for pulse_bcd_counter
module tb_pulse_bcd_counter;

    localparam int DIGITS = 4;
    localparam int SS     = 2;
    localparam int GC     = 1000;

    typedef struct {
        int          npulse;
        int          hi;
        int          lo;
        bit          hold;
        logic [15:0] rel_bcd;
        logic [15:0] exp_bcd;
        bit          exp_ovf;
        int          exp_cv;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pulse_in = 1'b0;
    logic        clear = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        count_valid;

    int   checks = 0;
    int   errors = 0;
    int   cv_cnt = 0;
    int   cyc = 0;
    bit   bad_nibble = 0;
    int   first, cnt, disp, np, exp_cv, last;
    bit   do_clr, new_hold, got, stop;
    vec_t v;
    vec_t vecs[7];

    pulse_bcd_counter #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SS),
        .GATE_CYCLES (GC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pulse_in    (pulse_in),
        .clear       (clear),
        .hold        (hold),
        .bcd_out     (bcd_out),
        .overflow    (overflow),
        .count_valid (count_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (count_valid) cv_cnt++;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_out[4*k +: 4] > 4'd9) bad_nibble = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        repeat (hi) @(negedge clock);
        pulse_in = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    task automatic settle();
        repeat (6) @(negedge clock);
    endtask

    function automatic logic [15:0] to_bcd(input int val);
        logic [15:0] r;
        int x;
        x = val;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_bcd", bcd_out, 16'h0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_cv", count_valid, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
`ifdef PULSE_CNT_GATE_EN
        stop = 0;
        fork
            begin
                while (!stop) begin
                    pulse_in = 1'b1;
                    @(negedge clock);
                    pulse_in = 1'b0;
                    repeat (9) @(negedge clock);
                end
            end
            begin
                last = 0;
                for (int w = 0; w < 3; w++) begin
                    got = 0;
                    for (int c = 0; c < 1500 && !got; c++) begin
                        @(negedge clock);
                        if (count_valid) got = 1;
                    end
                    chk("gate_strobe_seen", got, 1'b1);
                    chk("gate_window_count", (bcd_out >= 16'h0099 && bcd_out <= 16'h0101), 1'b1);
                    if (w > 0) chk("gate_period", cyc - last, 1000);
                    last = cyc;
                end
                @(negedge clock);
                cv_cnt = 0;
                repeat (899) @(negedge clock);
                chk("gate_single_strobe", cv_cnt, 0);
                @(posedge clock);
                #3 reset_n = 1'b0;
                #1;
                chk("gate_async_reset_bcd", bcd_out, 16'h0);
                chk("gate_async_reset_ovf", overflow, 1'b0);
                chk("gate_async_reset_cv", count_valid, 1'b0);
                stop = 1;
            end
        join
`else
        // First pulse: exact latency from sampled rise to display update.
        cv_cnt = 0;
        first = 0;
        pulse_in = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (n == 4) pulse_in = 1'b0;
            if (count_valid && first == 0) first = n;
        end
        chk("first_update_latency", first, SS + 2);
        repeat (6) pulse(4, 4);
        settle();
        chk("t1_bcd", bcd_out, 16'h0007);
        chk("t1_cv_count", cv_cnt, 7);

        // Count through carry boundaries and the wrap.
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        settle();
        chk("clear_bcd", bcd_out, 16'h0);
        for (int i = 1; i <= 10000; i++) begin
            pulse(1, 1);
            if (i == 99 || i == 100 || i == 999 || i == 1000 || i == 9999 || i == 10000) begin
                settle();
                chk($sformatf("count_%0d_bcd", i), bcd_out, to_bcd(i % 10000));
                chk($sformatf("count_%0d_ovf", i), overflow, (i == 10000));
            end
        end
        repeat (3) pulse(4, 4);
        settle();
        chk("post_wrap_bcd", bcd_out, 16'h0003);
        chk("post_wrap_ovf", overflow, 1'b1);

        // Clear on the same cycle as an increment: pulse dropped.
        cv_cnt = 0;
        pulse_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (3) @(negedge clock);
        pulse_in = 1'b0;
        settle();
        chk("clr_inc_bcd", bcd_out, 16'h0);
        chk("clr_inc_ovf", overflow, 1'b0);
        chk("clr_inc_cv", cv_cnt, 0);
        pulse(4, 4);
        settle();
        chk("clr_inc_dropped", bcd_out, 16'h0001);

        // Clear while hold is active.
        hold = 1'b1;
        pulse(4, 4);
        pulse(4, 4);
        settle();
        chk("hold_clr_pre", bcd_out, 16'h0001);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("hold_clr_bcd", bcd_out, 16'h0);
        chk("hold_clr_ovf", overflow, 1'b0);
        hold = 1'b0;
        @(negedge clock);
        chk("hold_clr_release", {count_valid, bcd_out}, {1'b1, 16'h0});
        settle();

        // Table-driven hold/release rows.
        vecs[0] = '{12, 4, 4, 1'b0, 16'h0000, 16'h0012, 1'b0, 12};
        vecs[1] = '{30, 1, 1, 1'b0, 16'h0000, 16'h0042, 1'b0, 30};
        vecs[2] = '{5,  2, 3, 1'b1, 16'h0000, 16'h0042, 1'b0, 0};
        vecs[3] = '{0,  1, 1, 1'b0, 16'h0047, 16'h0047, 1'b0, 1};
        vecs[4] = '{53, 1, 2, 1'b0, 16'h0000, 16'h0100, 1'b0, 53};
        vecs[5] = '{3,  3, 1, 1'b1, 16'h0000, 16'h0100, 1'b0, 0};
        vecs[6] = '{1,  4, 4, 1'b0, 16'h0103, 16'h0104, 1'b0, 2};
        for (int r = 0; r < 7; r++) begin
            v = vecs[r];
            cv_cnt = 0;
            if (hold && !v.hold) begin
                hold = 1'b0;
                @(negedge clock);
                chk($sformatf("row%0d_release_bcd", r), bcd_out, v.rel_bcd);
                chk($sformatf("row%0d_release_cv", r), count_valid, 1'b1);
            end
            hold = v.hold;
            repeat (v.npulse) pulse(v.hi, v.lo);
            settle();
            chk($sformatf("row%0d_bcd", r), bcd_out, v.exp_bcd);
            chk($sformatf("row%0d_ovf", r), overflow, v.exp_ovf);
            chk($sformatf("row%0d_cv", r), cv_cnt, v.exp_cv);
        end

        // Randomized operations against an integer reference model.
        cnt = 104;
        disp = 104;
        for (int op = 0; op < 40; op++) begin
            do_clr = ($urandom_range(0, 7) == 0);
            new_hold = ($urandom_range(0, 3) == 0);
            np = $urandom_range(0, 12);
            cv_cnt = 0;
            if (do_clr) begin
                clear = 1'b1;
                @(negedge clock);
                clear = 1'b0;
                cnt = 0;
                disp = 0;
            end
            exp_cv = (hold && !new_hold) ? 1 : 0;
            hold = new_hold;
            for (int p = 0; p < np; p++) pulse($urandom_range(1, 4), $urandom_range(1, 4));
            settle();
            cnt = (cnt + np) % 10000;
            if (!new_hold) begin
                disp = cnt;
                exp_cv = exp_cv + np;
            end
            chk($sformatf("rand%0d_bcd", op), bcd_out, to_bcd(disp));
            chk($sformatf("rand%0d_cv", op), cv_cnt, exp_cv);
            chk($sformatf("rand%0d_ovf", op), overflow, 1'b0);
        end

        hold = 1'b0;
        pulse(2, 2);
        settle();
        chk("pre_reset_bcd", bcd_out, to_bcd((cnt + 1) % 10000));
        chk("nibble_never_above_9", bad_nibble, 1'b0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_bcd", bcd_out, 16'h0);
        chk("async_reset_ovf", overflow, 1'b0);
        chk("async_reset_cv", count_valid, 1'b0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
